// File: rtl/pkt_gen_seq_ctl.sv
// Packet-generation sequencer for the fcs_pkt input side (32-bit lane path).
// Emits preamble, SFD, then the frame body (DA, SA, len/type, incrementing
// payload, no FCS), followed by an idle gap that keeps fcs_pkt's CRC and
// terminate slots clear of the next preamble.
module pkt_gen_seq_ctl #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 9600,
    parameter int MIN_GAP = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_pkt_gen_pls,
    input  logic             stop_pkt_gen_pls,
    input  logic [13:0]      cfg_pkt_len,
    input  logic [15:0]      cfg_num_pkts,
    input  logic [7:0]       cfg_ipg_cyc,
    input  logic [47:0]      cfg_dst_mac,
    input  logic [47:0]      cfg_src_mac,
    output logic             o_preamble_vld,
    output logic             o_sfd_vld,
    output logic [3:0][7:0]  o_data,
    output logic [1:0]       o_bytes_vld,
    output logic             o_sop,
    output logic             o_eop,
    output logic             o_vld,
    output logic             o_busy,
    output logic             o_done_pls,
    output logic [15:0]      o_pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_IPG
    } state_t;

    localparam logic [13:0] MIN_LEN_C = MIN_LEN[13:0];
    localparam logic [13:0] MAX_LEN_C = MAX_LEN[13:0];
    localparam logic [7:0]  MIN_GAP_C = MIN_GAP[7:0];

    state_t          state_q, state_d;
    logic [13:0]     len_q, len_d;
    logic [7:0]      gap_q, gap_d;
    logic [15:0]     num_q, num_d;
    logic [47:0]     da_q, da_d;
    logic [47:0]     sa_q, sa_d;
    logic [13:0]     idx_q, idx_d;       // byte index of lane [3] in the current beat
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            stop_pend_q, stop_pend_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;

    logic            pre_q, pre_d;
    logic            sfd_q, sfd_d;
    logic [3:0][7:0] data_q, data_d;
    logic [1:0]      bv_q, bv_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            vld_q, vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            last_beat;
    logic            run_over;

    // Body byte k of a frame of length len; bytes at or past len read as zero.
    function automatic logic [7:0] body_byte(input logic [13:0] k,
                                             input logic [13:0] len,
                                             input logic [47:0] da,
                                             input logic [47:0] sa);
        logic [13:0] lt;
        lt = len - 14'd14;
        body_byte = 8'h00;
        if (k >= len) begin
            body_byte = 8'h00;
        end else if (k < 14'd12) begin
            case (k[3:0])
                4'd0:    body_byte = da[47:40];
                4'd1:    body_byte = da[39:32];
                4'd2:    body_byte = da[31:24];
                4'd3:    body_byte = da[23:16];
                4'd4:    body_byte = da[15:8];
                4'd5:    body_byte = da[7:0];
                4'd6:    body_byte = sa[47:40];
                4'd7:    body_byte = sa[39:32];
                4'd8:    body_byte = sa[31:24];
                4'd9:    body_byte = sa[23:16];
                4'd10:   body_byte = sa[15:8];
                4'd11:   body_byte = sa[7:0];
                default: body_byte = 8'h00;
            endcase
        end else if (k == 14'd12) begin
            body_byte = {2'b00, lt[13:8]};
        end else if (k == 14'd13) begin
            body_byte = lt[7:0];
        end else begin
            body_byte = 8'(k - 14'd14);
        end
    endfunction

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        gap_d       = gap_q;
        num_d       = num_q;
        da_d        = da_q;
        sa_d        = sa_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        pkt_cnt_d   = pkt_cnt_q;
        done_d      = 1'b0;

        last_beat = ({1'b0, idx_q} + 15'd4) >= {1'b0, len_q};
        run_over  = stop_pend_q || stop_pkt_gen_pls ||
                    ((num_q != 16'd0) && (pkt_cnt_q == num_q));

        if ((state_q != S_IDLE) && stop_pkt_gen_pls) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_pkt_gen_pls) begin
                    if (cfg_pkt_len < MIN_LEN_C) begin
                        len_d = MIN_LEN_C;
                    end else if (cfg_pkt_len > MAX_LEN_C) begin
                        len_d = MAX_LEN_C;
                    end else begin
                        len_d = cfg_pkt_len;
                    end
                    gap_d       = (cfg_ipg_cyc < MIN_GAP_C) ? MIN_GAP_C : cfg_ipg_cyc;
                    num_d       = cfg_num_pkts;
                    da_d        = cfg_dst_mac;
                    sa_d        = cfg_src_mac;
                    pkt_cnt_d   = 16'd0;
                    stop_pend_d = stop_pkt_gen_pls;
                    state_d     = S_PRE;
                end
            end
            S_PRE: begin
                state_d = S_SFD;
            end
            S_SFD: begin
                idx_d   = 14'd0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (last_beat) begin
                    gap_cnt_d = gap_q;
                    pkt_cnt_d = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
                    state_d   = S_IPG;
                end else begin
                    idx_d = idx_q + 14'd4;
                end
            end
            S_IPG: begin
                if (gap_cnt_q <= 8'd1) begin
                    if (run_over) begin
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_PRE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        pre_d  = (state_d == S_PRE);
        sfd_d  = (state_d == S_SFD);
        vld_d  = (state_d == S_DATA);
        busy_d = (state_d != S_IDLE);
        data_d = '0;
        sop_d  = 1'b0;
        eop_d  = 1'b0;
        bv_d   = 2'd0;
        if (state_d == S_DATA) begin
            data_d[3] = body_byte(idx_d,          len_q, da_q, sa_q);
            data_d[2] = body_byte(idx_d + 14'd1,  len_q, da_q, sa_q);
            data_d[1] = body_byte(idx_d + 14'd2,  len_q, da_q, sa_q);
            data_d[0] = body_byte(idx_d + 14'd3,  len_q, da_q, sa_q);
            sop_d     = (idx_d == 14'd0);
            eop_d     = ({1'b0, idx_d} + 15'd4) >= {1'b0, len_q};
            bv_d      = eop_d ? len_q[1:0] : 2'd0;
        end
    end

    // State, configuration, counters and output registers; reset aborts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            gap_q       <= '0;
            num_q       <= '0;
            da_q        <= '0;
            sa_q        <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            pkt_cnt_q   <= '0;
            pre_q       <= 1'b0;
            sfd_q       <= 1'b0;
            data_q      <= '0;
            bv_q        <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            num_q       <= num_d;
            da_q        <= da_d;
            sa_q        <= sa_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pre_q       <= pre_d;
            sfd_q       <= sfd_d;
            data_q      <= data_d;
            bv_q        <= bv_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_preamble_vld = pre_q;
    assign o_sfd_vld      = sfd_q;
    assign o_data         = data_q;
    assign o_bytes_vld    = bv_q;
    assign o_sop          = sop_q;
    assign o_eop          = eop_q;
    assign o_vld          = vld_q;
    assign o_busy         = busy_q;
    assign o_done_pls     = done_q;
    assign o_pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_gen_seq_ctl.sv
// Scoreboard bench for pkt_gen_seq_ctl: expected output events (with the cycle
// they must appear in) are queued when a run is launched; a monitor pops and
// compares every cycle in which the DUT shows preamble, SFD, data or done.
module tb_pkt_gen_seq_ctl;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_pkt_gen_pls;
    logic            stop_pkt_gen_pls;
    logic [13:0]     cfg_pkt_len;
    logic [15:0]     cfg_num_pkts;
    logic [7:0]      cfg_ipg_cyc;
    logic [47:0]     cfg_dst_mac;
    logic [47:0]     cfg_src_mac;
    logic            o_preamble_vld;
    logic            o_sfd_vld;
    logic [3:0][7:0] o_data;
    logic [1:0]      o_bytes_vld;
    logic            o_sop;
    logic            o_eop;
    logic            o_vld;
    logic            o_busy;
    logic            o_done_pls;
    logic [15:0]     o_pkt_cnt;

    typedef struct {
        int          cyc;
        logic [3:0]  fl;     // {done, vld, sfd, pre}
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  bv;
        logic [15:0] cnt;
        logic        busy;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    pkt_gen_seq_ctl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_pkt_gen_pls (start_pkt_gen_pls),
        .stop_pkt_gen_pls  (stop_pkt_gen_pls),
        .cfg_pkt_len       (cfg_pkt_len),
        .cfg_num_pkts      (cfg_num_pkts),
        .cfg_ipg_cyc       (cfg_ipg_cyc),
        .cfg_dst_mac       (cfg_dst_mac),
        .cfg_src_mac       (cfg_src_mac),
        .o_preamble_vld    (o_preamble_vld),
        .o_sfd_vld         (o_sfd_vld),
        .o_data            (o_data),
        .o_bytes_vld       (o_bytes_vld),
        .o_sop             (o_sop),
        .o_eop             (o_eop),
        .o_vld             (o_vld),
        .o_busy            (o_busy),
        .o_done_pls        (o_done_pls),
        .o_pkt_cnt         (o_pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Expected body byte k of a frame of length len.
    function automatic logic [7:0] mb(input int k, input int len,
                                      input logic [47:0] da, input logic [47:0] sa);
        if (k >= len) return 8'h00;
        if (k < 6) return da[47-8*k -: 8];
        if (k < 12) return sa[47-8*(k-6) -: 8];
        if (k == 12) return 8'((len - 14) >> 8);
        if (k == 13) return 8'(len - 14);
        return 8'((k - 14) % 256);
    endfunction

    task automatic push_pkt(input int tp, input int len, input logic [47:0] da,
                            input logic [47:0] sa, input logic [15:0] cnt);
        ev_t e;
        int  beats;
        beats  = (len + 3) / 4;
        e.cyc  = tp;     e.fl = 4'b0001; e.data = '0; e.sop = 1'b0; e.eop = 1'b0;
        e.bv   = 2'd0;   e.cnt = cnt;    e.busy = 1'b1;
        exp_q.push_back(e);
        e.cyc  = tp + 1; e.fl = 4'b0010;
        exp_q.push_back(e);
        for (int i = 0; i < beats; i++) begin
            e.cyc  = tp + 2 + i;
            e.fl   = 4'b0100;
            e.data = {mb(4*i, len, da, sa), mb(4*i+1, len, da, sa),
                      mb(4*i+2, len, da, sa), mb(4*i+3, len, da, sa)};
            e.sop  = (i == 0);
            e.eop  = (i == beats - 1);
            e.bv   = e.eop ? 2'(len % 4) : 2'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input int t, input logic [15:0] cnt);
        ev_t e;
        e.cyc = t; e.fl = 4'b1000; e.data = '0; e.sop = 1'b0; e.eop = 1'b0;
        e.bv = 2'd0; e.cnt = cnt; e.busy = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cyc=%0d)", nm, act, req, cyc);
        end
    endtask

    task automatic monitor();
        ev_t        e;
        logic [3:0] fl;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                fl = {o_done_pls, o_vld, o_sfd_vld, o_preamble_vld};
                checks++;
                if (fl != 4'b0000) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: cyc=%0d flags=%b data=%h eop=%b cnt=%0d",
                                 cyc, fl, o_data, o_eop, o_pkt_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.fl != fl || e.data != o_data || e.sop != o_sop ||
                            e.eop != o_eop || e.bv != o_bytes_vld || e.cnt != o_pkt_cnt ||
                            e.busy != o_busy) begin
                            errors++;
                            $display("FAIL event: got cyc=%0d fl=%b data=%h sop=%b eop=%b bv=%0d cnt=%0d busy=%b, expected cyc=%0d fl=%b data=%h sop=%b eop=%b bv=%0d cnt=%0d busy=%b",
                                     cyc, fl, o_data, o_sop, o_eop, o_bytes_vld, o_pkt_cnt, o_busy,
                                     e.cyc, e.fl, e.data, e.sop, e.eop, e.bv, e.cnt, e.busy);
                        end
                    end
                end else if (o_sop || o_eop || o_data != '0 || o_bytes_vld != 2'd0) begin
                    errors++;
                    $display("FAIL idle_outputs: cyc=%0d sop=%b eop=%b data=%h bv=%0d, expected all 0",
                             cyc, o_sop, o_eop, o_data, o_bytes_vld);
                end
            end
        end
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_pending_events"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start_pkt_gen_pls = 1'b1;
        @(posedge clk); #1;
        start_pkt_gen_pls = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_pkt_gen_pls = 1'b1;
        @(posedge clk); #1;
        stop_pkt_gen_pls = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_cfg(input logic [13:0] len, input logic [15:0] num, input logic [7:0] ipg);
        cfg_pkt_len  = len;
        cfg_num_pkts = num;
        cfg_ipg_cyc  = ipg;
    endtask

    logic [47:0] da0 = 48'hA1B2C3D4E5F6;
    logic [47:0] sa0 = 48'h0F1E2D3C4B5A;

    initial begin
        int T;
        int b;
        rst_n = 1'b0;
        start_pkt_gen_pls = 1'b0;
        stop_pkt_gen_pls  = 1'b0;
        cfg_dst_mac = da0;
        cfg_src_mac = sa0;
        set_cfg(14'd60, 16'd1, 8'd0);
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({o_preamble_vld, o_sfd_vld, o_data, o_bytes_vld, o_sop,
                                  o_eop, o_vld, o_busy, o_done_pls, o_pkt_cnt}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: minimum frame, single packet, gap raised to minimum
        set_cfg(14'd60, 16'd1, 8'd0);
        T = cyc;
        push_pkt(T + 1, 60, da0, sa0, 16'd0);
        push_done(T + 21, 16'd1);
        pulse_start();
        wait_drain("t1", 100);
        chk("t1_pkt_cnt", 64'(o_pkt_cnt), 64'd1);
        chk("t1_busy", 64'(o_busy), 64'd0);

        // 2: 65-byte frames, two packets, 12-cycle gap
        set_cfg(14'd65, 16'd2, 8'd12);
        T = cyc;
        b = exp_q.size();
        push_pkt(T + 1, 65, da0, sa0, 16'd0);
        exp_q[b + 18].data = 32'h32000000;
        exp_q[b + 18].bv   = 2'd1;
        push_pkt(T + 32, 65, da0, sa0, 16'd1);
        push_done(T + 63, 16'd2);
        pulse_start();
        wait_drain("t2", 200);
        chk("t2_pkt_cnt", 64'(o_pkt_cnt), 64'd2);

        // 3: header layout with known MACs
        cfg_dst_mac = 48'h001122334455;
        cfg_src_mac = 48'h66778899AABB;
        set_cfg(14'd100, 16'd1, 8'd5);
        T = cyc;
        b = exp_q.size();
        push_pkt(T + 1, 100, 48'h001122334455, 48'h66778899AABB, 16'd0);
        exp_q[b + 2].data = 32'h00112233;
        exp_q[b + 3].data = 32'h44556677;
        exp_q[b + 4].data = 32'h8899AABB;
        exp_q[b + 5].data = 32'h00560001;
        push_done(T + 33, 16'd1);
        pulse_start();
        wait_drain("t3", 100);
        cfg_dst_mac = da0;
        cfg_src_mac = sa0;

        // 4: continuous mode stopped mid-DATA of the third packet
        set_cfg(14'd60, 16'd0, 8'd0);
        T = cyc;
        push_pkt(T + 1,  60, da0, sa0, 16'd0);
        push_pkt(T + 21, 60, da0, sa0, 16'd1);
        push_pkt(T + 41, 60, da0, sa0, 16'd2);
        push_done(T + 61, 16'd3);
        pulse_start();
        wait_until(T + 50);
        pulse_stop();
        wait_drain("t4", 200);
        chk("t4_pkt_cnt", 64'(o_pkt_cnt), 64'd3);
        chk("t4_busy", 64'(o_busy), 64'd0);

        // 5a: short request clamped up to 60 bytes
        set_cfg(14'd10, 16'd1, 8'd0);
        T = cyc;
        push_pkt(T + 1, 60, da0, sa0, 16'd0);
        push_done(T + 21, 16'd1);
        pulse_start();
        wait_drain("t5a", 100);

        // 5b: long request clamped down to 9600 bytes; a start while busy is ignored
        set_cfg(14'd16000, 16'd1, 8'd0);
        T = cyc;
        push_pkt(T + 1, 9600, da0, sa0, 16'd0);
        push_done(T + 2406, 16'd1);
        pulse_start();
        wait_until(T + 100);
        set_cfg(14'd60, 16'd5, 8'd20);
        pulse_start();
        wait_drain("t5b", 3000);

        // 7: start and stop together in IDLE sends exactly one packet
        set_cfg(14'd60, 16'd3, 8'd0);
        T = cyc;
        push_pkt(T + 1, 60, da0, sa0, 16'd0);
        push_done(T + 21, 16'd1);
        start_pkt_gen_pls = 1'b1;
        stop_pkt_gen_pls  = 1'b1;
        @(posedge clk); #1;
        start_pkt_gen_pls = 1'b0;
        stop_pkt_gen_pls  = 1'b0;
        wait_drain("t7", 150);
        chk("t7_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

        // 8: stop in IDLE is not remembered by the next run
        pulse_stop();
        @(posedge clk); #1;
        set_cfg(14'd60, 16'd2, 8'd0);
        T = cyc;
        push_pkt(T + 1,  60, da0, sa0, 16'd0);
        push_pkt(T + 21, 60, da0, sa0, 16'd1);
        push_done(T + 41, 16'd2);
        pulse_start();
        wait_drain("t8", 150);
        chk("t8_pkt_cnt", 64'(o_pkt_cnt), 64'd2);

        // 6: asynchronous reset during DATA, then a normal run
        set_cfg(14'd60, 16'd1, 8'd0);
        T = cyc;
        b = exp_q.size();
        push_pkt(T + 1, 60, da0, sa0, 16'd0);
        while (exp_q.size() > b + 8) void'(exp_q.pop_back());
        pulse_start();
        wait_until(T + 8);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs", 64'({o_preamble_vld, o_sfd_vld, o_data, o_bytes_vld,
                                           o_sop, o_eop, o_vld, o_busy, o_done_pls, o_pkt_cnt}),
            64'd0);
        chk("t6_beats_before_reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t6_idle_after_reset", 64'({o_busy, o_pkt_cnt}), 64'd0);
        T = cyc;
        push_pkt(T + 1, 60, da0, sa0, 16'd0);
        push_done(T + 21, 16'd1);
        pulse_start();
        wait_drain("t6_rerun", 100);
        chk("t6_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
